// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor acquisition controller: FSM state
// encoding and default geometry of the sample buffer.
package sensor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = $clog2(DEPTH);

endpackage

// File: rtl/sensor_buf.sv
// DEPTH x DATA_W sample register file: one write port, one registered read
// port. A same-cycle read of the slot being written returns the old word.
module sensor_buf #(
    parameter int DATA_W = sensor_pkg::DATA_W,
    parameter int DEPTH  = sensor_pkg::DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    import sensor_pkg::*;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  word_we;
    logic [DATA_W-1:0] rdata_q;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word_we
            assign word_we[gi] = we && (waddr == ADDR_W'(gi));
        end
    endgenerate

    // The whole array clears under reset, so it stays in fabric registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (word_we[i]) begin
                    mem_q[i] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sensor_ctrl.sv
// Acquisition controller: fills the sample buffer from the sensor while
// enabled, raises a level interrupt once all slots are written.
module sensor_ctrl #(
    parameter int DATA_W = sensor_pkg::DATA_W,
    parameter int DEPTH  = sensor_pkg::DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sctrl_en,
    input  logic              sctrl_clear,
    input  logic [ADDR_W-1:0] sctrl_addr,
    input  logic              sensor_ready,
    input  logic [DATA_W-1:0] sensor_out,
    output logic              sensor_en,
    output logic              sctrl_interrupt,
    output logic [DATA_W-1:0] sctrl_out
);
    import sensor_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              irq_q, irq_d;
    logic              wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        wr_en    = 1'b0;
        // Clear beats everything, including a sample arriving the same cycle.
        if (sctrl_clear) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sctrl_en) begin
                        state_d = FILL;
                    end
                end
                FILL: begin
                    if (!sctrl_en) begin
                        state_d = IDLE;
                    end
                    if (sensor_ready) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    state_d = FULL;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        irq_d = (state_d == FULL);
    end

    assign sensor_en       = (state_q == FILL);
    assign sctrl_interrupt = irq_q;

    sensor_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (sensor_out),
        .raddr (sctrl_addr),
        .rdata (sctrl_out)
    );

endmodule

// File: tb/tb_sensor_ctrl.sv
// Directed bench for sensor_ctrl: fill, readback, gapped fill, clear
// collision, full hold and asynchronous reset, with a read scoreboard.
module tb_sensor_ctrl;
    import sensor_pkg::*;

    logic        clk;
    logic        rst;
    logic        sctrl_en;
    logic        sctrl_clear;
    logic [5:0]  sctrl_addr;
    logic        sensor_ready;
    logic [31:0] sensor_out;
    logic        sensor_en;
    logic        sctrl_interrupt;
    logic [31:0] sctrl_out;

    int n_vec;
    int n_err;
    logic [31:0] model_mem [64];
    logic [31:0] exp_q [$];

    sensor_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .sctrl_en        (sctrl_en),
        .sctrl_clear     (sctrl_clear),
        .sctrl_addr      (sctrl_addr),
        .sensor_ready    (sensor_ready),
        .sensor_out      (sensor_out),
        .sensor_en       (sensor_en),
        .sctrl_interrupt (sctrl_interrupt),
        .sctrl_out       (sctrl_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read with scoreboard: expectation queued at drive time, popped one cycle later.
    task automatic rd(input logic [5:0] addr);
        logic [31:0] e;
        sctrl_addr = addr;
        exp_q.push_back(model_mem[addr]);
        step();
        e = exp_q.pop_front();
        chk($sformatf("read[%0d]", addr), sctrl_out, e);
        $display("read slot %0d -> %h (expected %h)", addr, sctrl_out, e);
    endtask

    task automatic wr(input logic [5:0] slot, input logic [31:0] data);
        sensor_ready = 1'b1;
        sensor_out   = data;
        step();
        model_mem[slot] = data;
        sensor_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        rst = 1'b0;
        sctrl_en = 1'b0;
        sctrl_clear = 1'b0;
        sctrl_addr = '0;
        sensor_ready = 1'b0;
        sensor_out = '0;

        // Reset state
        #3;
        chk("rst_sensor_en", 32'(sensor_en), 32'd0);
        chk("rst_irq", 32'(sctrl_interrupt), 32'd0);
        chk("rst_out", sctrl_out, 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_ptr", 32'(dut.wr_ptr_q), 32'd0);

        // Back-to-back fill of all 64 slots
        sctrl_en = 1'b1;
        step();
        chk("fill_enter", 32'(sensor_en), 32'd1);
        for (int i = 0; i < 64; i++) begin
            chk("fill_ptr", 32'(dut.wr_ptr_q), 32'(i));
            if (i == 63) chk("fill_irq_early", 32'(sctrl_interrupt), 32'd0);
            sensor_ready = 1'b1;
            sensor_out = 32'h100 + 32'(i);
            step();
            model_mem[i] = 32'h100 + 32'(i);
        end
        sensor_ready = 1'b0;
        $display("fill done: sensor_en=%0b irq=%0b", sensor_en, sctrl_interrupt);
        chk("fill_sensor_en", 32'(sensor_en), 32'd0);
        chk("fill_irq", 32'(sctrl_interrupt), 32'd1);
        chk("fill_state", 32'(dut.state_q), 32'(FULL));
        chk("fill_ptr_wrap", 32'(dut.wr_ptr_q), 32'd0);

        // Readback against fixed constants and the model
        sctrl_addr = 6'h05;
        step();
        chk("rb_05", sctrl_out, 32'h105);
        sctrl_addr = 6'h3F;
        step();
        chk("rb_3f", sctrl_out, 32'h13F);
        rd(6'd0);
        rd(6'd17);

        // Full hold: samples ignored, interrupt stays up
        sensor_ready = 1'b1;
        sensor_out = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_irq", 32'(sctrl_interrupt), 32'd1);
        end
        rd(6'd0);
        rd(6'd63);
        rd(6'd31);
        sensor_ready = 1'b0;

        // Clear together with enable: IDLE first, FILL one cycle later
        sctrl_clear = 1'b1;
        step();
        sctrl_clear = 1'b0;
        chk("clr_irq", 32'(sctrl_interrupt), 32'd0);
        chk("clr_state", 32'(dut.state_q), 32'(IDLE));
        chk("clr_ptr", 32'(dut.wr_ptr_q), 32'd0);
        chk("clr_sensor_en", 32'(sensor_en), 32'd0);
        step();
        chk("reenter_state", 32'(dut.state_q), 32'(FILL));
        chk("reenter_sensor_en", 32'(sensor_en), 32'd1);

        // Gapped fill: one ready pulse every third cycle
        for (int k = 0; k < 64; k++) begin
            step();
            step();
            chk("gap_ptr", 32'(dut.wr_ptr_q), 32'(k));
            if (k == 63) chk("gap_irq_early", 32'(sctrl_interrupt), 32'd0);
            wr(6'(k), 32'h200 + 32'(k));
        end
        chk("gap_irq", 32'(sctrl_interrupt), 32'd1);
        chk("gap_state", 32'(dut.state_q), 32'(FULL));
        rd(6'd0);
        rd(6'd63);

        // Clear collision and enable drop mid-fill
        sctrl_clear = 1'b1;
        sctrl_en = 1'b0;
        step();
        sctrl_clear = 1'b0;
        step();
        chk("coll_idle", 32'(dut.state_q), 32'(IDLE));
        sctrl_en = 1'b1;
        step();
        for (int i = 0; i < 5; i++) wr(6'(i), 32'h300 + 32'(i));
        sctrl_en = 1'b0;
        step();
        chk("drop_state", 32'(dut.state_q), 32'(IDLE));
        wr(6'd5, 32'h0000_0BAD);
        model_mem[5] = 32'h205;
        chk("idle_ignore_ptr", 32'(dut.wr_ptr_q), 32'd5);
        rd(6'd5);
        sctrl_en = 1'b1;
        step();
        for (int i = 5; i < 10; i++) begin
            // Read the slot being written: old contents expected
            sctrl_addr = 6'(i);
            exp_q.push_back(model_mem[i]);
            wr(6'(i), 32'h300 + 32'(i));
            chk("rd_during_wr", sctrl_out, exp_q.pop_front());
        end
        chk("coll_ptr10", 32'(dut.wr_ptr_q), 32'd10);
        sctrl_clear = 1'b1;
        sensor_ready = 1'b1;
        sensor_out = 32'h0000_DEAD;
        step();
        sctrl_clear = 1'b0;
        sensor_ready = 1'b0;
        sctrl_en = 1'b0;
        chk("coll_ptr", 32'(dut.wr_ptr_q), 32'd0);
        chk("coll_state", 32'(dut.state_q), 32'(IDLE));
        chk("coll_irq", 32'(sctrl_interrupt), 32'd0);
        rd(6'd10);
        rd(6'd9);

        // Asynchronous reset in the middle of a fill
        sctrl_en = 1'b1;
        step();
        for (int i = 0; i < 3; i++) wr(6'(i), 32'h400 + 32'(i));
        sctrl_addr = 6'd1;
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        chk("arst_sensor_en", 32'(sensor_en), 32'd0);
        chk("arst_irq", 32'(sctrl_interrupt), 32'd0);
        chk("arst_out", sctrl_out, 32'd0);
        chk("arst_ptr", 32'(dut.wr_ptr_q), 32'd0);
        sctrl_en = 1'b0;
        step();
        rst = 1'b1;
        step();
        sctrl_en = 1'b1;
        step();
        wr(6'd0, 32'h0000_04AA);
        chk("post_rst_ptr", 32'(dut.wr_ptr_q), 32'd1);
        sctrl_en = 1'b0;
        rd(6'd0);
        rd(6'd1);
        rd(6'd2);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
